// File: rtl/stat_engine.sv
// stat_engine
//   Sequential statistics unit. It accepts N unsigned W-bit samples over a
//   valid handshake and returns MAX, MIN, MEAN or VAR of the set. The opcode
//   is latched together with start.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_start      begin an operation; only looked at in IDLE
//   i_op         00=MAX 01=MIN 10=MEAN 11=VAR; latched with i_start
//   i_din        sample data
//   i_din_valid  i_din valid this cycle; only consumed in LOAD
//   o_busy       high in LOAD and CALC
//   o_done       one-cycle pulse; o_out is valid
//   o_out        result, zero-extended to 2W; held until the next CALC
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; accumulators cleared when start is seen
// S_LOAD | accumulating samples on i_din_valid, stalls allowed
// S_CALC | one cycle: derive mean/var and register the selected result
// S_DONE | one cycle: o_done pulse, then back to idle

module stat_engine #(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int LOG2N = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [W-1:0]     i_din,
  input  logic             i_din_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [2*W-1:0]   o_out
);

  localparam int CW  = $clog2(N + 1);
  localparam int SW  = W + LOG2N;
  localparam int QW  = 2 * W + LOG2N;

  localparam logic [1:0] OP_MAX  = 2'b00;
  localparam logic [1:0] OP_MIN  = 2'b01;
  localparam logic [1:0] OP_MEAN = 2'b10;
  localparam logic [1:0] OP_VAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]     r_op;
  logic [CW-1:0]  r_cnt;
  logic [SW-1:0]  r_sum;
  logic [QW-1:0]  r_sumsq;
  logic [W-1:0]   r_max;
  logic [W-1:0]   r_min;
  logic [2*W-1:0] r_out;

  logic           w_launch;
  logic           w_accept;
  logic           w_last;
  logic [2*W-1:0] w_din_ext;
  logic [2*W-1:0] w_din_sq;
  logic [W-1:0]   w_mean;
  logic [2*W-1:0] w_mean_ext;
  logic [2*W-1:0] w_mean_sq;
  logic [2*W-1:0] w_sumsq_div;
  logic [2*W-1:0] w_var;
  logic [2*W-1:0] w_result;

  // ------------------------------------------------------------------
  // Handshake qualifiers
  // ------------------------------------------------------------------
  assign w_launch = (r_state == S_IDLE) && i_start;
  assign w_accept = (r_state == S_LOAD) && i_din_valid;
  // The Nth sample is the one accepted while the counter still reads N-1.
  assign w_last   = w_accept && (r_cnt == CW'(N - 1));

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and status outputs
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        o_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Sample arithmetic
  // ------------------------------------------------------------------
  assign w_din_ext = {{W{1'b0}}, i_din};
  assign w_din_sq  = w_din_ext * w_din_ext;

  // N is a power of two, so the divides are plain right shifts. The
  // floor of sum/N always fits in W bits and the floor of sumsq/N in 2W.
  assign w_mean      = W'(r_sum >> LOG2N);
  assign w_sumsq_div = (2*W)'(r_sumsq >> LOG2N);
  assign w_mean_ext  = {{W{1'b0}}, w_mean};
  assign w_mean_sq   = w_mean_ext * w_mean_ext;
  // floor(E[x^2]) >= floor(E[x])^2 for integer samples, so this never wraps.
  assign w_var       = w_sumsq_div - w_mean_sq;

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MAX:  w_result = {{W{1'b0}}, r_max};
      OP_MIN:  w_result = {{W{1'b0}}, r_min};
      OP_MEAN: w_result = w_mean_ext;
      OP_VAR:  w_result = w_var;
      default: w_result = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Opcode latch and accumulators
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op    <= OP_MAX;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_sumsq <= '0;
      r_max   <= '0;
      r_min   <= '1;
    end else if (w_launch) begin
      r_op    <= i_op;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_sumsq <= '0;
      r_max   <= '0;
      r_min   <= '1;
    end else if (w_accept) begin
      r_cnt   <= r_cnt + CW'(1);
      r_sum   <= r_sum + SW'(i_din);
      r_sumsq <= r_sumsq + QW'(w_din_sq);
      if (i_din > r_max) begin
        r_max <= i_din;
      end
      if (i_din < r_min) begin
        r_min <= i_din;
      end
    end
  end

  // ------------------------------------------------------------------
  // Result register: written only in CALC, so it survives IDLE and start
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out <= '0;
    end else if (r_state == S_CALC) begin
      r_out <= w_result;
    end
  end

  assign o_out = r_out;

endmodule
